instruction_fetch: RTL and testbench

Sequential fetch stage between the CPU core and the byte-wide, combinationally-read instruction ROM. Accepts a fetch request for a 32-bit program-counter address and drives the ROM address for four consecutive byte reads. Assembles the four bytes little-endian into a 32-bit instruction word and returns it over a valid/ready handshake. Misaligned requests and ROM illegal-address responses are reported as a fault that travels with the returned word.

---
 rtl/instruction_fetch_pkg.sv | 7 +
 rtl/instruction_fetch.sv | 85 ++++++++
 tb/tb_instruction_fetch.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/instruction_fetch_pkg.sv
// instruction_fetch_pkg: fetch FSM states and byte-assembly constants
// shared by the instruction fetch stage.
package instruction_fetch_pkg;
    localparam int INSTR_BYTES  = 4;
    localparam int BYTE_INDEX_W = 2;
    typedef enum logic [1:0] {IDLE, READ, DONE} state_t;
endpackage

// File: rtl/instruction_fetch.sv
// instruction_fetch: reads four ROM bytes per request and returns a little-endian word with a fault flag.
// Optional FETCH_MISALIGN_CHECK_EN faults any request whose address is not word aligned.
module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_ADDRESS = 32'h0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    input  logic [31:0] req_address,
    output logic        req_ready,
    output logic [31:0] rom_address,
    input  logic [7:0]  rom_data,
    input  logic        rom_illegal,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic        fault,
    input  logic        instr_ready
);
    state_t                  state_q, state_d;
    logic [BYTE_INDEX_W-1:0] idx_q, idx_d;
    logic [31:0]             base_q, base_d;
    logic [31:0]             instr_q, instr_d;
    logic                    fault_q, fault_d;
    logic                    accept;
    logic                    misalign;

    assign req_ready   = (state_q == IDLE) || (state_q == DONE && instr_ready);
    assign instr_valid = state_q == DONE;
    assign instr       = instr_q;
    assign fault       = fault_q;
    assign rom_address = (state_q == READ) ? base_q + 32'(idx_q) : base_q;
    assign accept      = req_valid && req_ready;
`ifdef FETCH_MISALIGN_CHECK_EN
    assign misalign = |req_address[1:0];
`else
    assign misalign = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        base_d  = base_q;
        instr_d = instr_q;
        fault_d = fault_q;
        if (state_q == READ) begin
            if (rom_illegal) begin
                instr_d = '0;
                fault_d = 1'b1;
                state_d = DONE;
            end else begin
                instr_d[8*idx_q +: 8] = rom_data;
                idx_d = idx_q + BYTE_INDEX_W'(1);
                if (idx_q == BYTE_INDEX_W'(INSTR_BYTES - 1))
                    state_d = DONE;
            end
        end else if (accept) begin
            // a DONE handshake can chain straight into the next fetch
            base_d  = req_address;
            instr_d = '0;
            idx_d   = '0;
            fault_d = misalign;
            state_d = misalign ? DONE : READ;
        end else if (state_q == DONE && instr_ready) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            base_q  <= RESET_ADDRESS;
            instr_q <= '0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            base_q  <= base_d;
            instr_q <= instr_d;
            fault_q <= fault_d;
        end
    end
endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: table-driven and randomized checks of instruction_fetch against a ROM model.
// Expectations follow FETCH_MISALIGN_CHECK_EN when it is defined for the build.
module tb_instruction_fetch;
    localparam logic [31:0] RST_ADDR = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic [31:0] req_address;
    logic        req_ready;
    logic [31:0] rom_address;
    logic [7:0]  rom_data;
    logic        rom_illegal;
    logic        instr_valid;
    logic [31:0] instr;
    logic        fault;
    logic        instr_ready;

    logic [7:0] rom [0:2047];
    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] addr;
        int          bp;
        logic [31:0] exp_instr;
        logic        exp_fault;
        int          exp_lat;
    } vec_t;

    instruction_fetch #(.RESET_ADDRESS(RST_ADDR)) dut (
        .clock(clk), .reset(reset), .req_valid(req_valid), .req_address(req_address),
        .req_ready(req_ready), .rom_address(rom_address), .rom_data(rom_data),
        .rom_illegal(rom_illegal), .instr_valid(instr_valid), .instr(instr),
        .fault(fault), .instr_ready(instr_ready)
    );

    always #5 clk = ~clk;

    assign rom_illegal = rom_address >= 32'h800;
    assign rom_data    = rom_illegal ? 8'h00 : rom[rom_address[10:0]];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: walk the four byte addresses, stop at the first illegal one.
    task automatic model(input logic [31:0] a, output logic [31:0] w, output logic f, output int lat);
        logic [31:0] x;
        w = 32'h0; f = 1'b0; lat = 4;
`ifdef FETCH_MISALIGN_CHECK_EN
        if (a % 4 != 0) begin
            f = 1'b1; lat = 0; return;
        end
`endif
        for (int k = 0; k < 4; k++) begin
            x = a + 32'(k);
            if (x >= 32'h800) begin
                w = 32'h0; f = 1'b1; lat = k + 1; return;
            end
            w = w | (32'(rom[x[10:0]]) << (8 * k));
        end
    endtask

    task automatic fetch(input logic [31:0] a, input int bp, input logic [31:0] ei, input logic ef, input int el);
        int n;
        logic [31:0] held;
        logic hf;
        @(negedge clk);
        instr_ready = 1'b0;
        req_valid   = 1'b1;
        req_address = a;
        chk("req_ready_idle", 32'(req_ready), 32'd1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        req_address = $urandom;
        n = 0;
        @(negedge clk);
        while (!instr_valid && n < 10) begin
            chk("rom_address_step", rom_address, a + 32'(n));
            @(posedge clk);
            n++;
            @(negedge clk);
        end
        chk("latency", 32'(n), 32'(el));
        chk("instr", instr, ei);
        chk("fault", 32'(fault), 32'(ef));
        held = instr;
        hf = fault;
        for (int i = 0; i < bp; i++) begin
            chk("req_ready_bp", 32'(req_ready), 32'd0);
            @(posedge clk);
            @(negedge clk);
            chk("valid_bp", 32'(instr_valid), 32'd1);
            chk("instr_bp", instr, held);
            chk("fault_bp", 32'(fault), 32'(hf));
        end
        instr_ready = 1'b1;
        #1 chk("req_ready_done", 32'(req_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        instr_ready = 1'b0;
        chk("valid_drop", 32'(instr_valid), 32'd0);
        chk("rom_address_idle", rom_address, a);
    endtask

    initial begin
        vec_t vt [$];
        logic [31:0] w, a;
        logic f;
        int lat, t0, t1;
        for (int i = 0; i < 2048; i++) rom[i] = 8'(i * 37 + 11);
        {rom[0], rom[1], rom[2], rom[3]} = {8'h13, 8'h05, 8'hA0, 8'h00};
        {rom[4], rom[5], rom[6], rom[7]} = {8'h93, 8'h05, 8'h10, 8'h00};

        vt.push_back('{32'h0000_0000, 0, 32'h00A0_0513, 1'b0, 4});
        vt.push_back('{32'h0000_0004, 3, 32'h0010_0593, 1'b0, 4});
        vt.push_back('{32'h0000_0800, 0, 32'h0,         1'b1, 1});
        vt.push_back('{32'h0000_07FC, 1, 32'hE6C1_9C77, 1'b0, 4});
`ifdef FETCH_MISALIGN_CHECK_EN
        vt.push_back('{32'h0000_07FE, 0, 32'h0,         1'b1, 0});
        vt.push_back('{32'h0000_0002, 2, 32'h0,         1'b1, 0});
        vt.push_back('{32'hFFFF_FFFF, 0, 32'h0,         1'b1, 0});
`else
        vt.push_back('{32'h0000_07FE, 0, 32'h0,         1'b1, 3});
        vt.push_back('{32'h0000_0002, 2, 32'h0593_00A0, 1'b0, 4});
        vt.push_back('{32'hFFFF_FFFF, 0, 32'h0,         1'b1, 1});
`endif

        reset = 1'b1; req_valid = 1'b0; req_address = 32'h0; instr_ready = 1'b0;
        #12;
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_valid", 32'(instr_valid), 32'd0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_fault", 32'(fault), 32'd0);
        chk("rst_rom_address", rom_address, RST_ADDR);
        @(negedge clk);
        reset = 1'b0;

        foreach (vt[i]) fetch(vt[i].addr, vt[i].bp, vt[i].exp_instr, vt[i].exp_fault, vt[i].exp_lat);

        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 3))
                0: a = {$urandom_range(0, 32'h1FF), 2'b00};
                1: a = $urandom_range(0, 32'h7FF);
                2: a = $urandom_range(32'h7F8, 32'h803);
                default: a = 32'hFFFF_FFFC + $urandom_range(0, 3);
            endcase
            model(a, w, f, lat);
            fetch(a, $urandom_range(0, 2), w, f, lat);
        end

        // back-to-back: second request accepted on the first handshake edge
        @(negedge clk);
        instr_ready = 1'b1; req_valid = 1'b1; req_address = 32'h0;
        @(posedge clk);
        #1 req_address = 32'h4;
        t0 = 0;
        @(negedge clk);
        while (!instr_valid && t0 < 10) begin
            @(negedge clk);
            t0++;
        end
        chk("b2b_first", instr, 32'h00A0_0513);
        chk("b2b_ready", 32'(req_ready), 32'd1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        chk("b2b_valid_drop", 32'(instr_valid), 32'd0);
        chk("b2b_rom_address", rom_address, 32'h4);
        t1 = 1;
        while (!instr_valid && t1 < 10) begin
            @(negedge clk);
            t1++;
        end
        chk("b2b_period", 32'(t1), 32'd5);
        chk("b2b_second", instr, 32'h0010_0593);
        chk("b2b_fault", 32'(fault), 32'd0);
        @(posedge clk);
        @(negedge clk);
        instr_ready = 1'b0;
        chk("b2b_idle", 32'(instr_valid), 32'd0);

        // asynchronous reset mid-READ
        @(negedge clk);
        req_valid = 1'b1; req_address = 32'h0;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_valid", 32'(instr_valid), 32'd0);
        chk("mid_rst_ready", 32'(req_ready), 32'd1);
        chk("mid_rst_rom_address", rom_address, RST_ADDR);
        @(negedge clk);
        reset = 1'b0;
        fetch(32'h0, 0, 32'h00A0_0513, 1'b0, 4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
